ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-port arbiter that shares the single-port word RAM between an instruction-fetch requester (m0) and a load/store requester (m1). Each cycle it grants at most one requester and drives the RAM write-enable, address and write data from the winner. For reads it registers the RAM's combinational read data into a one-cycle response to the winning requester. Arbitration is round-robin with a bounded burst, so neither requester can starve the other.

## Interface
- ADDR_W, 32, byte-address width; the RAM word index is addr[ADDR_W-1:2]
- DATA_W, 32, data width
- BURST_MAX, 4, max consecutive grants to one requester while the other is waiting (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- m0_req_i  in  1  m0 access request, level, valid for one cycle per access
- m0_we_i  in  1  m0 write (1) / read (0)
- m0_addr_i  in  ADDR_W  m0 byte address
- m0_data_i  in  DATA_W  m0 write data
- m0_gnt_o  out  1  combinational: m0 access performed this cycle
- m0_rvalid_o  out  1  registered: m0 read data valid this cycle
- m0_data_o  out  DATA_W  registered m0 read data
- m1_*: same seven signals for requester m1
- ram_we_o  out  1  RAM write enable
- ram_addr_o  out  ADDR_W  RAM byte address
- ram_data_o  out  DATA_W  RAM write data
- ram_data_i  in  DATA_W  RAM combinational read data for ram_addr_o

## Operation
- State: owner (1 bit, last granted requester), cnt (consecutive grants to owner, 0..BURST_MAX, saturating).
- Grant (combinational):
  - only one req high: grant it;
  - both high: grant owner if cnt < BURST_MAX, else the other;
  - none high: no grant.
- Exactly one or zero of m0_gnt_o/m1_gnt_o is high; a requester not granted must hold its req, we, addr and data until granted.
- RAM drive:
  - ram_we_o = winner's we_i & grant;
  - ram_addr_o and ram_data_o = winner's inputs;
  - all zero when there is no grant;
  - never write when there is no grant.
- State update at posedge:
  - grant to owner: cnt = min(cnt+1, BURST_MAX);
  - grant to other: owner = winner, cnt = 1;
  - no grant: cnt = 0, owner unchanged.
- Lone requester: granted every cycle regardless of cnt. cnt still saturates, so the other requester wins the first tie after it arrives.
- Read response:
  - granted read: at the next posedge, mX_data_o <= ram_data_i and mX_rvalid_o <= 1 for one cycle;
  - mX_data_o holds its value until the next read response to that requester;
  - granted write: gnt only, no rvalid.
- Reset (async, rst=1): owner=0, cnt=0, all rvalid=0, all data_o=0. Outputs are forced to these values immediately; the first tie after reset goes to m0.

## Timing
- Grant and RAM drive: same cycle as req (zero-cycle decision). The write commits at the posedge ending the granted cycle.
- Read latency: rvalid one cycle after gnt. Back-to-back granted reads give rvalid every cycle.
- Worst-case wait for a requesting master while the other streams: BURST_MAX cycles.
- Read and write to the same word by different masters in consecutive cycles: order follows the grant order. A read granted the cycle after a write returns the new data.
- Reset asserted mid-access: the in-flight rvalid is dropped; the RAM write of that cycle is not guaranteed.

## Test plan
- Reset: assert rst asynchronously between edges -> all rvalid/data_o read 0 immediately; the first tie grants m0.
- Single master: m1 writes 0xDEADBEEF to 0x10, then reads 0x10 -> m1_gnt_o=1 both cycles; m1_rvalid_o pulses the cycle after the read with m1_data_o=0xDEADBEEF; m0 outputs unchanged.
- Contention, BURST_MAX=4: m0 and m1 both request continuously from reset -> grant sequence m0 x4, m1 x4, m0 x4, ...; no cycle without a grant.
- Lone stream then arrival: m0 alone for 10 cycles, m1 raises req -> m1 granted on its first request cycle (cnt saturated).
- Hazard: m1 writes 0x1234 to 0x20 at cycle N, m0 reads 0x20 at N+1 -> m0_rvalid_o at N+2 with data 0x1234.
- Idle gap: both idle one cycle, then both request -> cnt cleared; the previous owner wins and receives up to BURST_MAX grants.

Source files
------------

// File: rtl/ram_arbiter.sv
// ============================================================================
// ram_arbiter : round-robin, burst-bounded arbiter for a single-port word RAM
// Rev 1.0
// ============================================================================
`default_nettype none

module ram_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  output logic [DATA_W-1:0] m0_data_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  input  logic [DATA_W-1:0] ram_data_i
);

  localparam int              CNT_W   = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] C_BURST = CNT_W'(BURST_MAX);

  logic              owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] data0_q, data0_d, data1_q, data1_d;
  logic              w_gnt0, w_gnt1;

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (m0_req_i && m1_req_i) begin
      // Owner keeps the RAM until its burst budget is spent.
      if (cnt_q < C_BURST) begin
        w_gnt0 = ~owner_q;
        w_gnt1 = owner_q;
      end else begin
        w_gnt0 = owner_q;
        w_gnt1 = ~owner_q;
      end
    end else begin
      w_gnt0 = m0_req_i;
      w_gnt1 = m1_req_i;
    end
  end

  always_comb begin
    ram_we_o   = 1'b0;
    ram_addr_o = '0;
    ram_data_o = '0;
    if (w_gnt0) begin
      ram_we_o   = m0_we_i;
      ram_addr_o = m0_addr_i;
      ram_data_o = m0_data_i;
    end else if (w_gnt1) begin
      ram_we_o   = m1_we_i;
      ram_addr_o = m1_addr_i;
      ram_data_o = m1_data_i;
    end
  end

  always_comb begin
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (!w_gnt0 && !w_gnt1) begin
      cnt_d = '0;
    end else if (w_gnt1 == owner_q) begin
      cnt_d = (cnt_q == C_BURST) ? cnt_q : cnt_q + CNT_W'(1);
    end else begin
      owner_d = w_gnt1;
      cnt_d   = CNT_W'(1);
    end
    rvalid0_d = w_gnt0 & ~m0_we_i;
    rvalid1_d = w_gnt1 & ~m1_we_i;
    data0_d   = rvalid0_d ? ram_data_i : data0_q;
    data1_d   = rvalid1_d ? ram_data_i : data1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q   <= 1'b0;
      cnt_q     <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      data0_q   <= '0;
      data1_q   <= '0;
    end else begin
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      data0_q   <= data0_d;
      data1_q   <= data1_d;
    end
  end

  assign m0_gnt_o    = w_gnt0;
  assign m1_gnt_o    = w_gnt1;
  assign m0_rvalid_o = rvalid0_q;
  assign m1_rvalid_o = rvalid1_q;
  assign m0_data_o   = data0_q;
  assign m1_data_o   = data1_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// ============================================================================
// tb_ram_arbiter : vector table plus directed sequences for ram_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [31:0] mem [0:255];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(32), .DATA_W(32), .BURST_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_data_i(m0_wdata),
    .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_data_o(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_data_i(m1_wdata),
    .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_data_o(m1_rdata),
    .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_data_o(ram_wdata),
    .ram_data_i(ram_rdata)
  );

  // Single-port word RAM with combinational read
  assign ram_rdata = mem[ram_addr[9:2]];
  always @(posedge clk) if (ram_we) mem[ram_addr[9:2]] <= ram_wdata;

  typedef struct {
    logic        r0, w0; logic [31:0] a0, d0;
    logic        r1, w1; logic [31:0] a1, d1;
    logic        eg0, eg1, ewe; logic [31:0] eaddr;
    logic        erv0; logic [31:0] ed0;
    logic        erv1; logic [31:0] ed1;
  } vec_t;

  function automatic vec_t mk(
    input logic r0, w0, input logic [31:0] a0, d0,
    input logic r1, w1, input logic [31:0] a1, d1,
    input logic eg0, eg1, ewe, input logic [31:0] eaddr,
    input logic erv0, input logic [31:0] ed0,
    input logic erv1, input logic [31:0] ed1);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.eg0 = eg0; v.eg1 = eg1; v.ewe = ewe; v.eaddr = eaddr;
    v.erv0 = erv0; v.ed0 = ed0; v.erv1 = erv1; v.ed1 = ed1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r0, w0, input logic [31:0] a0, d0,
                       input logic r1, w1, input logic [31:0] a1, d1);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
  endtask

  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] H  = 32'h0000_1234;

  vec_t vt [18];

  initial begin
    // single master write/read, hazard, contention with reads, idle gap
    vt[0]  = mk(0,0,0,0,     1,1,32'h10,DB, 0,1,1,32'h10, 0,0,  0,0);
    vt[1]  = mk(0,0,0,0,     1,0,32'h10,0,  0,1,0,32'h10, 0,0,  0,0);
    vt[2]  = mk(0,0,0,0,     0,0,0,0,       0,0,0,0,      0,0,  1,DB);
    vt[3]  = mk(0,0,0,0,     1,1,32'h20,H,  0,1,1,32'h20, 0,0,  0,DB);
    vt[4]  = mk(1,0,32'h20,0,0,0,0,0,       1,0,0,32'h20, 0,0,  0,DB);
    vt[5]  = mk(0,0,0,0,     0,0,0,0,       0,0,0,0,      1,H,  0,DB);
    vt[6]  = mk(1,0,32'h10,0,1,0,32'h20,0,  1,0,0,32'h10, 0,H,  0,DB);
    vt[7]  = mk(1,0,32'h10,0,1,0,32'h20,0,  1,0,0,32'h10, 1,DB, 0,DB);
    vt[8]  = mk(1,0,32'h10,0,1,0,32'h20,0,  1,0,0,32'h10, 1,DB, 0,DB);
    vt[9]  = mk(1,0,32'h10,0,1,0,32'h20,0,  1,0,0,32'h10, 1,DB, 0,DB);
    vt[10] = mk(1,0,32'h10,0,1,0,32'h20,0,  0,1,0,32'h20, 1,DB, 0,DB);
    vt[11] = mk(1,0,32'h10,0,1,0,32'h20,0,  0,1,0,32'h20, 0,DB, 1,H);
    vt[12] = mk(1,0,32'h10,0,1,0,32'h20,0,  0,1,0,32'h20, 0,DB, 1,H);
    vt[13] = mk(1,0,32'h10,0,1,0,32'h20,0,  0,1,0,32'h20, 0,DB, 1,H);
    vt[14] = mk(1,0,32'h10,0,1,0,32'h20,0,  1,0,0,32'h10, 0,DB, 1,H);
    vt[15] = mk(1,0,32'h10,0,1,0,32'h20,0,  1,0,0,32'h10, 1,DB, 0,H);
    vt[16] = mk(0,0,0,0,     0,0,0,0,       0,0,0,0,      1,DB, 0,H);
    vt[17] = mk(1,0,32'h10,0,1,0,32'h20,0,  1,0,0,32'h10, 0,DB, 0,H);

    drive(0,0,0,0, 0,0,0,0);
    #1;
    check("rst_rv0", {31'b0, m0_rvalid}, 0);
    check("rst_rv1", {31'b0, m1_rvalid}, 0);
    check("rst_d0", m0_rdata, 0);
    check("rst_d1", m1_rdata, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(vt[i].r0, vt[i].w0, vt[i].a0, vt[i].d0, vt[i].r1, vt[i].w1, vt[i].a1, vt[i].d1);
      #1;
      check($sformatf("v%0d_gnt0", i), {31'b0, m0_gnt}, {31'b0, vt[i].eg0});
      check($sformatf("v%0d_gnt1", i), {31'b0, m1_gnt}, {31'b0, vt[i].eg1});
      check($sformatf("v%0d_we", i), {31'b0, ram_we}, {31'b0, vt[i].ewe});
      check($sformatf("v%0d_addr", i), ram_addr, vt[i].eaddr);
      check($sformatf("v%0d_rv0", i), {31'b0, m0_rvalid}, {31'b0, vt[i].erv0});
      check($sformatf("v%0d_d0", i), m0_rdata, vt[i].ed0);
      check($sformatf("v%0d_rv1", i), {31'b0, m1_rvalid}, {31'b0, vt[i].erv1});
      check($sformatf("v%0d_d1", i), m1_rdata, vt[i].ed1);
    end

    // Lone m0 stream saturates cnt; m1 must win its first tie
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      drive(1,0,32'h10,0, 0,0,0,0);
      #1;
      check($sformatf("lone%0d_gnt0", k), {31'b0, m0_gnt}, 1);
    end
    @(negedge clk);
    drive(1,0,32'h10,0, 1,0,32'h20,0);
    #1;
    check("arrive_gnt1", {31'b0, m1_gnt}, 1);
    check("arrive_gnt0", {31'b0, m0_gnt}, 0);
    @(negedge clk);
    #1;
    check("arrive2_gnt1", {31'b0, m1_gnt}, 1);

    // Idle gap: previous owner m1 gets a fresh full burst
    @(negedge clk);
    drive(0,0,0,0, 0,0,0,0);
    #1;
    check("gap_nognt", {30'b0, m0_gnt, m1_gnt}, 0);
    check("gap_we", {31'b0, ram_we}, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive(1,0,32'h10,0, 1,0,32'h20,0);
      #1;
      check($sformatf("gap%0d_gnt", k), {30'b0, m0_gnt, m1_gnt}, (k < 4) ? 32'd1 : 32'd2);
    end

    // Asynchronous reset between edges drops the pending response
    @(negedge clk);
    drive(0,0,0,0, 1,0,32'h10,0);
    @(posedge clk);
    #2;
    check("pre_rst_rv1", {31'b0, m1_rvalid}, 1);
    check("pre_rst_d1", m1_rdata, DB);
    rst = 1'b1;
    #1;
    check("async_rv1", {31'b0, m1_rvalid}, 0);
    check("async_d1", m1_rdata, 0);
    check("async_d0", m0_rdata, 0);
    check("async_rv0", {31'b0, m0_rvalid}, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1,0,32'h10,0, 1,0,32'h20,0);
    #1;
    check("post_rst_tie", {30'b0, m0_gnt, m1_gnt}, 2);

    @(negedge clk);
    drive(0,0,0,0, 0,0,0,0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
